// File: rtl/quant2_agc_if.sv
// quant2_agc_if: sample/control/status bundle between the requantizer and its
// environment. The master drives samples and freeze; the slave (the AGC)
// returns the quantized code and servo status.
interface quant2_agc_if;
  logic signed [7:0] x;
  logic signed [7:0] dc;
  logic              freeze;
  logic [1:0]        q;
  logic [6:0]        thr;
  logic [7:0]        frac;
  logic              update;
  logic              locked;

  modport master (output x, dc, freeze, input q, thr, frac, update, locked);
  modport slave  (input x, dc, freeze, output q, thr, frac, update, locked);
endinterface

// File: rtl/quant2_agc.sv
// quant2_agc: DC-corrected 2-bit sign/magnitude requantizer with a windowed
// threshold servo that steers the large-magnitude fraction toward TARGET.
// Optional feature macro: QUANT_DC_CORR_EN enables subtraction of the dc
// estimate in stage 1; when undefined the dc input is ignored and the
// pipeline depth stays the same.
module quant2_agc #(
  parameter int WIN_LOG2 = 16,
  parameter int TARGET   = 85,
  parameter int DEADBAND = 6,
  parameter int THR_INIT = 16,
  parameter int THR_MIN  = 1,
  parameter int THR_MAX  = 127
) (
  input  logic         clk,
  input  logic         rst,
  quant2_agc_if.slave  bus
);

  typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

  logic signed [13:0]  y_q, y_d;
  logic [1:0]          q_q, q_d;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [WIN_LOG2:0]   l_q;
  logic [6:0]          thr_q, thr_d;
  logic [7:0]          frac_q;
  logic                update_q;
  state_t              state_q, state_d;
  logic                histValid_q, histValid_d;
  logic                histSide_q, histSide_d;

  logic signed [13:0]  xScaled;
  logic signed [13:0]  thrScaled;
  logic                isLarge;
  logic                winClose;
  logic [WIN_LOG2:0]   lTotal;
  logic [8:0]          lShift;
  logic [7:0]          fVal;
  logic                hi, lo;
  int                  step;
  int                  thrUp, thrDn;

  // x scaled into 1/32 LSB units, sign-extended to the 14-bit datapath
  assign xScaled = {bus.x[7], bus.x, 5'b00000};

`ifdef QUANT_DC_CORR_EN
  assign y_d = xScaled - {{6{bus.dc[7]}}, bus.dc};
`else
  logic unusedDc;
  assign unusedDc = ^bus.dc;
  assign y_d = xScaled;
`endif

  // Threshold in the same 1/32 LSB units as y; always non-negative
  assign thrScaled = {2'b00, thr_q, 5'b00000};

  // Stage-2 sign/magnitude decision against the current threshold
  always_comb begin
    q_d = 2'b10;
    if (y_q >= thrScaled)
      q_d = 2'b01;
    else if (y_q >= 14'sd0)
      q_d = 2'b00;
    else if (y_q > -thrScaled)
      q_d = 2'b11;
  end

  // Window bookkeeping: the closing cycle's own sample is folded into F
  assign isLarge  = (q_q == 2'b01) || (q_q == 2'b10);
  assign winClose = &cnt_q;
  assign lTotal   = l_q + {{WIN_LOG2{1'b0}}, isLarge};
  assign lShift   = 9'(lTotal >> (WIN_LOG2 - 8));
  assign fVal     = lShift[8] ? 8'hFF : lShift[7:0];

  assign hi = int'(fVal) > (TARGET + DEADBAND);
  assign lo = int'(fVal) < (TARGET - DEADBAND);

  assign step  = (state_q == TRACK) ? 1 : 4;
  assign thrUp = int'(thr_q) + step;
  assign thrDn = int'(thr_q) - step;

  // Servo: threshold step, ACQUIRE/TRACK transitions and same-side history,
  // all evaluated only on a window close and held entirely while frozen
  always_comb begin
    thr_d       = thr_q;
    state_d     = state_q;
    histValid_d = histValid_q;
    histSide_d  = histSide_q;
    if (winClose && !bus.freeze) begin
      if (hi)
        thr_d = (thrUp > THR_MAX) ? 7'(THR_MAX) : 7'(thrUp);
      else if (lo)
        thr_d = (thrDn < THR_MIN) ? 7'(THR_MIN) : 7'(thrDn);
      case (state_q)
        ACQUIRE: begin
          histValid_d = 1'b0;
          if (!hi && !lo)
            state_d = TRACK;
        end
        TRACK: begin
          if (!hi && !lo) begin
            histValid_d = 1'b0;
          end else if (histValid_q && (histSide_q == hi)) begin
            state_d     = ACQUIRE;
            histValid_d = 1'b0;
          end else begin
            histValid_d = 1'b1;
            histSide_d  = hi;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // Pipeline, window counters and servo state; reset discards any partial window
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      q_q         <= 2'b00;
      cnt_q       <= '0;
      l_q         <= '0;
      thr_q       <= 7'(THR_INIT);
      frac_q      <= 8'd0;
      update_q    <= 1'b0;
      state_q     <= ACQUIRE;
      histValid_q <= 1'b0;
      histSide_q  <= 1'b0;
    end else begin
      y_q         <= y_d;
      q_q         <= q_d;
      cnt_q       <= cnt_q + {{(WIN_LOG2-1){1'b0}}, 1'b1};
      update_q    <= winClose;
      if (winClose) begin
        frac_q <= fVal;
        l_q    <= '0;
      end else begin
        l_q    <= lTotal;
      end
      thr_q       <= thr_d;
      state_q     <= state_d;
      histValid_q <= histValid_d;
      histSide_q  <= histSide_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.thr    = thr_q;
  assign bus.frac   = frac_q;
  assign bus.update = update_q;
  assign bus.locked = (state_q == TRACK);

endmodule

// File: tb/tb_quant2_agc.sv
// tb_quant2_agc: scoreboard bench for quant2_agc with 256-clock windows.
// dutA uses THR_INIT=16; dutS and dutM exercise the THR_MAX / THR_MIN clamps.
module tb_quant2_agc;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] qExp[$];
  int         thrExp[$];
  int         fracExp[$];
  int         lockExp[$];

  int xMode  = 0;
  int xConst = 0;

  quant2_agc_if busA();
  quant2_agc_if busS();
  quant2_agc_if busM();

  quant2_agc #(.WIN_LOG2(8), .THR_INIT(16))  dutA (.clk(clk), .rst(rst), .bus(busA));
  quant2_agc #(.WIN_LOG2(8), .THR_INIT(126)) dutS (.clk(clk), .rst(rst), .bus(busS));
  quant2_agc #(.WIN_LOG2(8), .THR_INIT(2))   dutM (.clk(clk), .rst(rst), .bus(busM));

  // Free-running sample clock
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected stage-2 code for one sample at a given threshold
  function automatic logic [1:0] refQ(int xv, int dv, int t);
    int y;
    int tt;
    y = xv * 32;
`ifdef QUANT_DC_CORR_EN
    y = y - dv;
`endif
    tt = t * 32;
    if (y >= tt) return 2'b01;
    if (y >= 0) return 2'b00;
    if (y > -tt) return 2'b11;
    return 2'b10;
  endfunction

  // Advance one clock and drive the next dutA sample (constant or random)
  task automatic tick();
    @(negedge clk);
    if (xMode == 1)
      busA.x = 8'(int'($urandom_range(95, 0)) - 48);
    else
      busA.x = 8'(xConst);
  endtask

  // Wait for the next dutA update pulse, reporting the clocks elapsed
  task automatic waitUpdate(output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      gap++;
      if (busA.update === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Hold reset for a few clocks and release it on a falling edge
  task automatic doReset();
    rst = 1'b1;
    busA.freeze = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for a window that lands in TRACK with an in-band frac (history clear)
  task automatic waitInBandLock(input int maxWin, output int thr0, output bit ok);
    int gap;
    bit got;
    ok = 1'b0;
    thr0 = 0;
    for (int w = 0; w < maxWin; w++) begin
      waitUpdate(gap, got);
      if (!got) break;
      if (busA.locked === 1'b1 && int'(busA.frac) >= 79 && int'(busA.frac) <= 91) begin
        ok = 1'b1;
        thr0 = int'(busA.thr);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    busA.x = 8'sd100; busA.dc = 8'sd0; busA.freeze = 1'b0;
    busS.x = 8'sd0; busS.dc = 8'sd0; busS.freeze = 1'b0;
    busM.x = 8'sd0; busM.dc = 8'sd0; busM.freeze = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (busA.q !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_q: got %b, expected 00", busA.q); end
    compared++;
    if (busA.thr !== 7'd16) begin mismatched++; $display("[TB] FAIL reset_thr: got %0d, expected 16", busA.thr); end
    compared++;
    if (busA.frac !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_frac: got %0d, expected 0", busA.frac); end
    compared++;
    if (busA.update !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_update: got %b, expected 0", busA.update); end
    compared++;
    if (busA.locked !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_locked: got %b, expected 0", busA.locked); end
    compared++;
    if (busS.thr !== 7'd126) begin mismatched++; $display("[TB] FAIL reset_thr_s: got %0d, expected 126", busS.thr); end
  endtask

  // Two-clock x/dc to q latency with fixed boundary samples then random ones
  task automatic test_latency_dc();
    int xs[$];
    int ds[$];
    int n;
    logic [1:0] e;
    xs = '{20, -5, 0, -16, 16, 15, -15, 16, -16, 127, -128};
    ds = '{0, 0, 0, 0, 0, 0, 0, 32, -32, -128, 127};
    for (int i = 0; i < 30; i++) begin
      xs.push_back(int'($urandom_range(255, 0)) - 128);
      ds.push_back(int'($urandom_range(255, 0)) - 128);
    end
    n = xs.size();
    xMode = 0;
    doReset();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = qExp.pop_front();
        compared++;
        if (busA.q !== e) begin
          mismatched++;
          $display("[TB] FAIL latency_q[%0d]: got %b, expected %b", i - 2, busA.q, e);
        end
      end
      if (i < n) begin
        busA.x  = 8'(xs[i]);
        busA.dc = 8'(ds[i]);
        qExp.push_back(refQ(xs[i], ds[i], 16));
      end
    end
    busA.dc = 8'sd0;
  endtask

  // Constant +100: thr climbs by 4 to 100, then bounces 104/100
  task automatic test_acquire();
    int gap;
    bit ok;
    int t;
    xMode = 0;
    xConst = 100;
    busA.x = 8'sd100;
    doReset();
    t = 16;
    for (int k = 1; k <= 25; k++) begin
      if (k == 1) fracExp.push_back(254);
      else if (t == 104) fracExp.push_back(1);
      else fracExp.push_back(255);
      if (t == 104) t = 100;
      else t = t + 4;
      thrExp.push_back(t);
    end
    while (thrExp.size() > 0) begin
      waitUpdate(gap, ok);
      compared++;
      if (!ok || gap != 256) begin
        mismatched++;
        $display("[TB] FAIL acquire_period: got %0d, expected 256", gap);
        thrExp.delete();
        fracExp.delete();
        break;
      end
      t = thrExp.pop_front();
      compared++;
      if (int'(busA.thr) != t) begin mismatched++; $display("[TB] FAIL acquire_thr: got %0d, expected %0d", busA.thr, t); end
      t = fracExp.pop_front();
      compared++;
      if (int'(busA.frac) != t) begin mismatched++; $display("[TB] FAIL acquire_frac: got %0d, expected %0d", busA.frac, t); end
      compared++;
      if (busA.locked !== 1'b0) begin mismatched++; $display("[TB] FAIL acquire_locked: got %b, expected 0", busA.locked); end
    end
  endtask

  // Uniform x in [-48,47]: the one-third point sits near thr 32-33
  task automatic test_lock();
    int gap;
    bit ok;
    bit seen;
    xMode = 1;
    doReset();
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      waitUpdate(gap, ok);
      if (!ok) break;
      if (busA.locked === 1'b1) begin seen = 1'b1; break; end
    end
    compared++;
    if (!seen) begin mismatched++; $display("[TB] FAIL lock_reached: got 0, expected 1"); end
    for (int w = 0; w < 8; w++) begin
      waitUpdate(gap, ok);
      compared++;
      if (!ok || int'(busA.thr) < 26 || int'(busA.thr) > 38) begin
        mismatched++;
        $display("[TB] FAIL lock_thr_range: got %0d, expected 26..38", busA.thr);
      end
    end
  endtask

  // From a clean TRACK state, two hi windows: first steps +1, second unlocks
  task automatic test_unlock();
    int gap;
    bit ok;
    int thr0;
    int e;
    waitInBandLock(40, thr0, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL unlock_setup: got 0, expected in-band lock"); return; end
    xMode = 0; xConst = 100; busA.x = 8'sd100;
    thrExp.push_back(thr0 + 1); lockExp.push_back(1);
    thrExp.push_back(thr0 + 2); lockExp.push_back(0);
    while (thrExp.size() > 0) begin
      waitUpdate(gap, ok);
      e = thrExp.pop_front();
      compared++;
      if (!ok || int'(busA.thr) != e) begin mismatched++; $display("[TB] FAIL unlock_thr: got %0d, expected %0d", busA.thr, e); end
      e = lockExp.pop_front();
      compared++;
      if (int'(busA.locked) != e) begin mismatched++; $display("[TB] FAIL unlock_locked: got %b, expected %0d", busA.locked, e); end
    end
  endtask

  // Freeze holds thr/locked while frac keeps refreshing; release resumes servo
  task automatic test_freeze();
    int gap;
    bit ok;
    int thr0;
    int e;
    xMode = 1;
    doReset();
    waitInBandLock(60, thr0, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL freeze_setup: got 0, expected in-band lock"); return; end
    busA.freeze = 1'b1;
    xMode = 0; xConst = 100; busA.x = 8'sd100;
    for (int w = 0; w < 3; w++) begin
      waitUpdate(gap, ok);
      compared++;
      if (!ok || int'(busA.thr) != thr0) begin mismatched++; $display("[TB] FAIL freeze_thr: got %0d, expected %0d", busA.thr, thr0); end
      compared++;
      if (busA.locked !== 1'b1) begin mismatched++; $display("[TB] FAIL freeze_locked: got %b, expected 1", busA.locked); end
      compared++;
      if ((w == 0 && int'(busA.frac) < 254) || (w > 0 && int'(busA.frac) != 255)) begin
        mismatched++;
        $display("[TB] FAIL freeze_frac: got %0d, expected 255", busA.frac);
      end
    end
    busA.freeze = 1'b0;
    thrExp.push_back(thr0 + 1); lockExp.push_back(1);
    thrExp.push_back(thr0 + 2); lockExp.push_back(0);
    while (thrExp.size() > 0) begin
      waitUpdate(gap, ok);
      e = thrExp.pop_front();
      compared++;
      if (!ok || int'(busA.thr) != e) begin mismatched++; $display("[TB] FAIL thaw_thr: got %0d, expected %0d", busA.thr, e); end
      e = lockExp.pop_front();
      compared++;
      if (int'(busA.locked) != e) begin mismatched++; $display("[TB] FAIL thaw_locked: got %b, expected %0d", busA.locked, e); end
    end
  endtask

  // THR_MAX clamp (126 -> 127 with x=127) and THR_MIN clamp (2 -> 1 with x=0)
  task automatic test_saturation();
    int gap;
    bit ok;
    int e;
    xMode = 0; xConst = 0; busA.x = 8'sd0;
    busS.x = 8'sd127;
    busM.x = 8'sd0;
    doReset();
    for (int w = 0; w < 3; w++) begin
      thrExp.push_back(127);
      fracExp.push_back(w == 0 ? 254 : 255);
    end
    while (thrExp.size() > 0) begin
      waitUpdate(gap, ok);
      e = thrExp.pop_front();
      compared++;
      if (!ok || int'(busS.thr) != e) begin mismatched++; $display("[TB] FAIL sat_max_thr: got %0d, expected %0d", busS.thr, e); end
      e = fracExp.pop_front();
      compared++;
      if (int'(busS.frac) != e) begin mismatched++; $display("[TB] FAIL sat_frac: got %0d, expected %0d", busS.frac, e); end
      compared++;
      if (busM.thr !== 7'd1) begin mismatched++; $display("[TB] FAIL sat_min_thr: got %0d, expected 1", busM.thr); end
      compared++;
      if (busM.frac !== 8'd0) begin mismatched++; $display("[TB] FAIL sat_min_frac: got %0d, expected 0", busM.frac); end
    end
  endtask

  initial begin
    $display("[TB] starting quant2_agc bench");
    test_reset();
    test_latency_dc();
    test_acquire();
    test_lock();
    test_unlock();
    test_freeze();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
